// File: rtl/mem_port_arbiter_if.sv
// Request/ack and SRAM signal bundle for the fetch/data memory port arbiter.
// master = requesters plus SRAM model side, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_wen;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;

    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    logic              busy;

    modport master (
        output if_req, if_addr, d_req, d_addr, d_wen, d_wdata, sram_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_wen, d_wdata, sram_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one SRAM port; ack 2 cycles after grant (write) or READ_LAT+2 (read).
// One access in flight; requesters hold req until ack, data wins unless a fetch has waited MAX_DATA_RUN data grants.
module mem_port_arbiter #(
    parameter int READ_LAT     = 1,
    parameter int MAX_DATA_RUN = 4,
    parameter int ADDR_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int RUN_W = 4;
    localparam int CNT_W = 3;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              own_data_q, own_data_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              sram_en_q, sram_en_d;
    logic [3:0]        sram_wen_q, sram_wen_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]       sram_wdata_q, sram_wdata_d;
    logic              busy_q, busy_d;
    logic              grant_data;

    // The sram_* registers double as the latched request: they hold it only for the ISSUE cycle.
    always_comb begin
        state_d      = state_q;
        own_data_d   = own_data_q;
        run_d        = run_q;
        cnt_d        = cnt_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        sram_en_d    = 1'b0;
        sram_wen_d   = 4'h0;
        sram_addr_d  = '0;
        sram_wdata_d = '0;
        grant_data   = 1'b0;

        case (state_q)
            IDLE: begin
                grant_data = bus.d_req && !(bus.if_req && (run_q == RUN_MAX));
                if (grant_data) begin
                    own_data_d   = 1'b1;
                    sram_en_d    = 1'b1;
                    sram_wen_d   = bus.d_wen;
                    sram_addr_d  = bus.d_addr;
                    sram_wdata_d = bus.d_wdata;
                    if (!bus.if_req)
                        run_d = '0;
                    else if (run_q != RUN_MAX)
                        run_d = run_q + RUN_W'(1);
                    state_d = ISSUE;
                end else if (bus.if_req) begin
                    own_data_d  = 1'b0;
                    sram_en_d   = 1'b1;
                    sram_addr_d = bus.if_addr;
                    run_d       = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (sram_wen_q != 4'h0) begin
                    d_ack_d  = own_data_q;
                    if_ack_d = !own_data_q;
                    state_d  = DONE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (own_data_q)
                        d_rdata_d = bus.sram_rdata;
                    else
                        if_rdata_d = bus.sram_rdata;
                    d_ack_d  = own_data_q;
                    if_ack_d = !own_data_q;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            own_data_q   <= 1'b0;
            run_q        <= '0;
            cnt_q        <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            sram_en_q    <= 1'b0;
            sram_wen_q   <= 4'h0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            own_data_q   <= own_data_d;
            run_q        <= run_d;
            cnt_q        <= cnt_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            sram_en_q    <= sram_en_d;
            sram_wen_q   <= sram_wen_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.if_ack     = if_ack_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.sram_en    = sram_en_q;
    assign bus.sram_wen   = sram_wen_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with READ_LAT=1, one with READ_LAT=3.
// Each SRAM model returns a junk word except exactly READ_LAT cycles after a read enable.
module tb_mem_port_arbiter;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst1, rst3;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(32)) b3 ();

    mem_port_arbiter #(.READ_LAT(1), .MAX_DATA_RUN(4), .ADDR_W(32)) dut1 (
        .clk(clk), .reset(rst1), .bus(b1.slave));
    mem_port_arbiter #(.READ_LAT(3), .MAX_DATA_RUN(4), .ADDR_W(32)) dut3 (
        .clk(clk), .reset(rst3), .bus(b3.slave));

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C1D_0001;
        if (a == 32'h0000_0200) return 32'h1234_5678;
        return a ^ 32'hA5A5_A5A5;
    endfunction

    logic [31:0] p1 = JUNK;
    logic [31:0] q1 = JUNK, q2 = JUNK, q3 = JUNK;
    always @(posedge clk) begin
        p1 <= (b1.sram_en && b1.sram_wen == 4'h0) ? rd_val(b1.sram_addr) : JUNK;
        q1 <= (b3.sram_en && b3.sram_wen == 4'h0) ? rd_val(b3.sram_addr) : JUNK;
        q2 <= q1;
        q3 <= q2;
    end
    assign b1.sram_rdata = p1;
    assign b3.sram_rdata = q3;

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1;
        repeat (2) @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        n_checks++; if ({b1.if_ack, b1.d_ack, b1.sram_en, b1.busy} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", {b1.if_ack, b1.d_ack, b1.sram_en, b1.busy}); end
        n_checks++; if (b1.if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata: got %h want 0", b1.if_rdata); end
        n_checks++; if (b1.d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h want 0", b1.d_rdata); end
        n_checks++; if (b1.sram_addr !== 32'h0) begin n_fail++; $display("FAIL reset_sram_addr: got %h want 0", b1.sram_addr); end
        n_checks++; if ({b1.sram_wen, b1.sram_wdata} !== 36'h0) begin n_fail++; $display("FAIL reset_sram_w: got %h want 0", {b1.sram_wen, b1.sram_wdata}); end
        n_checks++; if ({b3.busy, b3.d_ack, b3.sram_en} !== 3'b0) begin n_fail++; $display("FAIL reset_dut3: got %b want 000", {b3.busy, b3.d_ack, b3.sram_en}); end
    endtask

    task automatic test_fetch();
        b1.if_req = 1'b1; b1.if_addr = 32'hBFC0_0000;
        n_checks++; if (b1.sram_en !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_en: got %b want 0", b1.sram_en); end
        @(negedge clk);
        n_checks++; if (b1.sram_en !== 1'b1) begin n_fail++; $display("FAIL fetch_issue_en: got %b want 1", b1.sram_en); end
        n_checks++; if (b1.sram_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL fetch_addr: got %h want bfc00000", b1.sram_addr); end
        n_checks++; if ({b1.sram_wen, b1.busy} !== 5'b0000_1) begin n_fail++; $display("FAIL fetch_wen_busy: got %b want 00001", {b1.sram_wen, b1.busy}); end
        @(negedge clk);
        n_checks++; if ({b1.sram_en, b1.if_ack} !== 2'b00) begin n_fail++; $display("FAIL fetch_wait: got %b want 00", {b1.sram_en, b1.if_ack}); end
        @(negedge clk);
        n_checks++; if ({b1.if_ack, b1.d_ack} !== 2'b10) begin n_fail++; $display("FAIL fetch_ack: got %b want 10", {b1.if_ack, b1.d_ack}); end
        n_checks++; if (b1.if_rdata !== 32'h3C1D_0001) begin n_fail++; $display("FAIL fetch_rdata: got %h want 3c1d0001", b1.if_rdata); end
        b1.if_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({b1.if_ack, b1.busy} !== 2'b00) begin n_fail++; $display("FAIL fetch_end: got %b want 00", {b1.if_ack, b1.busy}); end
    endtask

    task automatic test_simultaneous();
        b1.if_req = 1'b1; b1.if_addr = 32'h400;
        b1.d_req = 1'b1; b1.d_addr = 32'h40; b1.d_wen = 4'h0; b1.d_wdata = 32'h0;
        @(negedge clk);
        n_checks++; if (b1.sram_addr !== 32'h40) begin n_fail++; $display("FAIL simul_first_addr: got %h want 40", b1.sram_addr); end
        repeat (2) @(negedge clk);
        n_checks++; if ({b1.d_ack, b1.if_ack} !== 2'b10) begin n_fail++; $display("FAIL simul_d_ack: got %b want 10", {b1.d_ack, b1.if_ack}); end
        n_checks++; if (b1.d_rdata !== 32'hA5A5_A5E5) begin n_fail++; $display("FAIL simul_d_rdata: got %h want a5a5a5e5", b1.d_rdata); end
        b1.d_req = 1'b0;
        @(negedge clk);
        n_checks++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL simul_idle: got %b want 0", b1.busy); end
        @(negedge clk);
        n_checks++; if ({b1.sram_en, b1.sram_addr} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL simul_fetch_issue: got %h want 1_00000400", {b1.sram_en, b1.sram_addr}); end
        repeat (2) @(negedge clk);
        n_checks++; if ({b1.if_ack, b1.d_ack} !== 2'b10) begin n_fail++; $display("FAIL simul_if_ack: got %b want 10", {b1.if_ack, b1.d_ack}); end
        n_checks++; if (b1.if_rdata !== 32'hA5A5_A1A5) begin n_fail++; $display("FAIL simul_if_rdata: got %h want a5a5a1a5", b1.if_rdata); end
        n_checks++; if (b1.d_rdata !== 32'hA5A5_A5E5) begin n_fail++; $display("FAIL simul_d_rdata_kept: got %h want a5a5a5e5", b1.d_rdata); end
        b1.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        b1.d_req = 1'b1; b1.d_wen = 4'hF; b1.d_addr = 32'h100; b1.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if ({b1.sram_en, b1.sram_wen} !== 5'b1_1111) begin n_fail++; $display("FAIL write_en_wen: got %b want 11111", {b1.sram_en, b1.sram_wen}); end
        n_checks++; if (b1.sram_addr !== 32'h100) begin n_fail++; $display("FAIL write_addr: got %h want 100", b1.sram_addr); end
        n_checks++; if (b1.sram_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_wdata: got %h want deadbeef", b1.sram_wdata); end
        b1.d_wdata = 32'h0; b1.d_addr = 32'h999;
        @(negedge clk);
        n_checks++; if ({b1.d_ack, b1.if_ack, b1.sram_en} !== 3'b100) begin n_fail++; $display("FAIL write_ack: got %b want 100", {b1.d_ack, b1.if_ack, b1.sram_en}); end
        n_checks++; if (b1.d_rdata !== 32'hA5A5_A5E5) begin n_fail++; $display("FAIL write_d_rdata_kept: got %h want a5a5a5e5", b1.d_rdata); end
        b1.d_req = 1'b0; b1.d_wen = 4'h0;
        @(negedge clk);
        n_checks++; if ({b1.d_ack, b1.busy} !== 2'b00) begin n_fail++; $display("FAIL write_end: got %b want 00", {b1.d_ack, b1.busy}); end
    endtask

    task automatic test_starvation();
        byte seq [6];
        byte exp_seq [6] = '{"D", "D", "D", "D", "F", "D"};
        int  n = 0;
        b1.d_req = 1'b1; b1.d_wen = 4'h0; b1.d_addr = 32'h80;
        b1.if_req = 1'b1; b1.if_addr = 32'h84;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (b1.if_ack && b1.d_ack) begin
                n_checks++; n_fail++;
                $display("FAIL starve_both_acks: got if_ack=1 d_ack=1 want at most one");
            end
            if (b1.d_ack) begin seq[n] = "D"; n++; end
            else if (b1.if_ack) begin seq[n] = "F"; n++; end
            if (n == 6) begin b1.d_req = 1'b0; b1.if_req = 1'b0; end
        end
        b1.d_req = 1'b0; b1.if_req = 1'b0;
        n_checks++; if (n != 6) begin n_fail++; $display("FAIL starve_timeout: got %0d acks want 6", n); end
        for (int i = 0; i < 6; i++) begin
            if (i < n) begin
                n_checks++;
                if (seq[i] != exp_seq[i]) begin n_fail++; $display("FAIL starve_order[%0d]: got %c want %c", i, seq[i], exp_seq[i]); end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_lat3();
        b3.d_req = 1'b1; b3.d_addr = 32'h200; b3.d_wen = 4'h0; b3.d_wdata = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) begin
                n_checks++; if (b3.d_ack !== 1'b0) begin n_fail++; $display("FAIL lat3_early_ack@%0d: got %b want 0", k, b3.d_ack); end
            end
            if (k == 4) begin
                n_checks++; if (b3.d_rdata !== 32'h0) begin n_fail++; $display("FAIL lat3_early_rdata: got %h want 0", b3.d_rdata); end
            end
        end
        n_checks++; if ({b3.d_ack, b3.if_ack} !== 2'b10) begin n_fail++; $display("FAIL lat3_ack: got %b want 10", {b3.d_ack, b3.if_ack}); end
        n_checks++; if (b3.d_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL lat3_rdata: got %h want 12345678", b3.d_rdata); end
        b3.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        b3.d_req = 1'b1; b3.d_addr = 32'h200; b3.d_wen = 4'h0;
        repeat (3) @(negedge clk);
        rst3 = 1'b1; b3.d_req = 1'b0;
        #1;
        n_checks++; if ({b3.busy, b3.sram_en, b3.d_ack} !== 3'b000) begin n_fail++; $display("FAIL rst_wait_outputs: got %b want 000", {b3.busy, b3.sram_en, b3.d_ack}); end
        @(negedge clk);
        rst3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++; if ({b3.d_ack, b3.if_ack, b3.busy} !== 3'b000) begin n_fail++; $display("FAIL rst_wait_quiet@%0d: got %b want 000", k, {b3.d_ack, b3.if_ack, b3.busy}); end
        end
        test_read_lat3();
    endtask

    task automatic test_reset_write_issue();
        b1.d_req = 1'b1; b1.d_wen = 4'h3; b1.d_addr = 32'h300; b1.d_wdata = 32'h0000_0001;
        @(negedge clk);
        n_checks++; if ({b1.sram_en, b1.sram_wen} !== 5'b1_0011) begin n_fail++; $display("FAIL rst_issue_pre: got %b want 10011", {b1.sram_en, b1.sram_wen}); end
        rst1 = 1'b1; b1.d_req = 1'b0; b1.d_wen = 4'h0;
        #1;
        n_checks++; if ({b1.sram_en, b1.sram_wen, b1.busy} !== 6'b0) begin n_fail++; $display("FAIL rst_issue_async: got %b want 000000", {b1.sram_en, b1.sram_wen, b1.busy}); end
        n_checks++; if (b1.sram_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_issue_wdata: got %h want 0", b1.sram_wdata); end
        @(negedge clk);
        rst1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (b1.d_ack !== 1'b0) begin n_fail++; $display("FAIL rst_issue_quiet@%0d: got %b want 0", k, b1.d_ack); end
        end
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_addr = '0; b1.d_wen = 4'h0; b1.d_wdata = '0;
        b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_addr = '0; b3.d_wen = 4'h0; b3.d_wdata = '0;
        test_reset();
        test_fetch();
        test_simultaneous();
        test_write();
        test_starvation();
        test_read_lat3();
        test_reset_in_wait();
        test_reset_write_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported synchronous SRAM between the instruction-fetch requester and the load/store data requester of the multi-cycle MIPS core. Requests use a request/acknowledge handshake. The block serialises them, one outstanding access at a time, and returns read data with an ack pulse. Data accesses have fixed priority, with an anti-starvation limit that guarantees fetch progress.

Parameters:
READ_LAT, 1, SRAM read latency in cycles from the enable cycle to valid sram_rdata; legal range 1..4.
MAX_DATA_RUN, 4, maximum consecutive data grants while a fetch is pending; legal range 1..15.
ADDR_W, 32, byte address width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
if_req  in  1  fetch request; held with if_addr until if_ack.
if_addr  in  ADDR_W  fetch byte address.
if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
if_rdata  out  32  fetched instruction; held until the next fetch ack.
d_req  in  1  data request; held with its payload until d_ack.
d_addr  in  ADDR_W  data byte address.
d_wen  in  4  byte write enables; 4'h0 means read.
d_wdata  in  32  store data.
d_ack  out  1  one-cycle pulse: data access complete.
d_rdata  out  32  load data; held until the next data read ack.
sram_en  out  1  SRAM access enable.
sram_wen  out  4  SRAM byte write enables.
sram_addr  out  ADDR_W  SRAM address.
sram_wdata  out  32  SRAM write data.
sram_rdata  in  32  SRAM read data.
busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset values: all outputs 0, state IDLE, data_run 0.
- IDLE arbitration:
  - If d_req and not (if_req and data_run==MAX_DATA_RUN): grant data.
  - Else if if_req: grant fetch.
  - Else stay in IDLE.
  - On a grant: latch owner, addr, wen (forced to 4'h0 for fetch) and wdata; go to ISSUE.
- data_run rules:
  - Increments on a data grant while if_req=1; saturates at MAX_DATA_RUN.
  - Clears on any fetch grant.
  - Clears on a data grant while if_req=0.
- ISSUE (exactly 1 cycle):
  - sram_en=1; sram_addr, sram_wen and sram_wdata come from the latched registers.
  - sram_* outputs are 0 in every other state.
  - Write (latched wen!=0): go to DONE.
  - Read: load a counter with READ_LAT and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, sram_rdata is captured into the owner's rdata register; go to DONE.
  - WAIT therefore lasts READ_LAT cycles.
- DONE (1 cycle):
  - Pulse the owner's ack (if_ack or d_ack), never both; go to IDLE.
  - Requests seen during DONE are ignored. A requester that keeps req high into the following IDLE cycle issues a new request.
- Latencies, counted from the IDLE cycle in which the grant occurs:
  - Write: ack 2 cycles later.
  - Read: ack READ_LAT+2 cycles later.
  - Minimum spacing between grants: 3 cycles for writes, READ_LAT+3 for reads.
- Other rules:
  - Requester changes to payload after the grant are ignored.
  - The address passes through unmodified; no alignment check.
  - The rdata register of the non-owner is not modified.
- Reset asserted mid-access:
  - Immediate return to IDLE; all outputs 0.
  - The in-flight access is abandoned with no ack.
  - If a write was in ISSUE, sram_en drops asynchronously.

Test Plan:
- Reset, fetch only: if_req=1, if_addr=0xBFC00000, READ_LAT=1, sram returns 0x3C1D0001 -> sram_en high 1 cycle with addr 0xBFC00000 and wen 0; if_ack at grant+3; if_rdata=0x3C1D0001; d_ack stays 0.
- Write: d_req, d_wen=4'hF, d_addr=0x100, d_wdata=0xDEADBEEF -> sram_en/wen=F/addr/wdata in ISSUE; d_ack at grant+2; d_rdata unchanged.
- Simultaneous if_req and d_req (read) -> data served first; d_ack, then fetch granted in the IDLE following DONE; if_ack follows.
- Starvation: d_req held high continuously with a fresh request after each d_ack, if_req held, MAX_DATA_RUN=4 -> exactly 4 data acks, then one fetch ack, then data resumes.
- READ_LAT=3 read of 0x200 with sram_rdata=0x12345678 valid only in the 3rd cycle after ISSUE -> d_ack at grant+5, d_rdata=0x12345678.
- Reset asserted in WAIT -> no ack at any later cycle; busy=0 and sram_en=0 immediately; a request after release is served normally.
